// File: rtl/pl_dac_tx.sv
// pl_dac_tx: burst streamer from an input sample FIFO to a parallel CMOS DAC bus.
// Bursts are requested by a rising edge on i_DAC_Work. The block primes the
// FIFO, then pops one sample per cycle onto the registered DAC bus.
// When the final sample of a burst is emitted, o_CMOS_Wr is high for that
// cycle and o_DAC_Done rises on the same edge. The DONE cycle then returns the
// bus to IDLE_CODE.
module pl_dac_tx #(
  parameter int                DATA_W      = 14,
  parameter int                BURST_LEN   = 200000,
  parameter int                FIFO_DEPTH  = 16,
  parameter int                PRIME_LEVEL = 4,
  parameter logic [DATA_W-1:0] IDLE_CODE   = 14'h2000
) (
  input  logic              i_CMOS_Clk,
  input  logic              i_Rst_n,
  input  logic              i_DAC_Work,
  input  logic [DATA_W-1:0] i_Sample_Data,
  input  logic              i_Sample_Valid,
  output logic              o_Sample_Ready,
  output logic [DATA_W-1:0] o_CMOS_Data,
  output logic              o_CMOS_Wr,
  output logic              o_DAC_Busy,
  output logic              o_DAC_Done,
  output logic              o_Underrun,
  output logic [19:0]       o_Sample_Count
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          OW        = AW + 1;
  localparam logic [OW-1:0] DEPTH_CNT = OW'(FIFO_DEPTH);
  localparam logic [OW-1:0] PRIME_CNT = OW'(PRIME_LEVEL);
  localparam logic [19:0] BURST_CNT = 20'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [OW-1:0]       occ_reg, occ_next;
  logic                ready_reg;
  logic                work_reg;
  logic                push, pop, start, empty;

  assign empty = (occ_reg == '0);
  // ready_reg is exactly !full, so push never overflows
  assign push  = i_Sample_Valid && ready_reg;
  assign start = i_DAC_Work && !work_reg;

  // next-state and pop decision; pop only happens in RUN with data present
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_PRIME;
      S_PRIME: if (occ_reg >= PRIME_CNT) state_next = S_RUN;
      S_RUN: begin
        if (!empty) begin
          pop = 1'b1;
          if (o_Sample_Count + 20'd1 == BURST_CNT) state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // occupancy update; simultaneous push and pop cancel out
  always_comb begin
    occ_next = occ_reg;
    case ({push, pop})
      2'b10:   occ_next = occ_reg + 1'b1;
      2'b01:   occ_next = occ_reg - 1'b1;
      default: occ_next = occ_reg;
    endcase
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge i_CMOS_Clk) begin
    if (push) mem[wr_ptr_reg] <= i_Sample_Data;
  end

  // FIFO pointers, occupancy and registered ready (low while in reset)
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
      ready_reg  <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      occ_reg   <= occ_next;
      ready_reg <= (occ_next != DEPTH_CNT);
    end
  end

  assign o_Sample_Ready = ready_reg;

  // state register, start edge detector and busy flag
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg  <= S_IDLE;
      work_reg   <= 1'b0;
      o_DAC_Busy <= 1'b0;
    end else begin
      state_reg  <= state_next;
      work_reg   <= i_DAC_Work;
      o_DAC_Busy <= (state_next == S_PRIME) || (state_next == S_RUN);
    end
  end

  // DAC bus, strobe and burst status registers
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_CMOS_Data    <= IDLE_CODE;
      o_CMOS_Wr      <= 1'b0;
      o_DAC_Done     <= 1'b0;
      o_Underrun     <= 1'b0;
      o_Sample_Count <= '0;
    end else begin
      o_CMOS_Wr <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          o_CMOS_Data <= IDLE_CODE;
          if (start) begin
            o_DAC_Done     <= 1'b0;
            o_Underrun     <= 1'b0;
            o_Sample_Count <= '0;
          end
        end
        S_PRIME: o_CMOS_Data <= IDLE_CODE;
        S_RUN: begin
          if (pop) begin
            o_CMOS_Data    <= mem[rd_ptr_reg];
            o_CMOS_Wr      <= 1'b1;
            o_Sample_Count <= o_Sample_Count + 20'd1;
            if (state_next == S_DONE) o_DAC_Done <= 1'b1;
          end else begin
            // starved: bus holds its last word
            o_Underrun <= 1'b1;
          end
        end
        S_DONE:  o_CMOS_Data <= IDLE_CODE;
        default: o_CMOS_Data <= IDLE_CODE;
      endcase
    end
  end

endmodule
